// File: rtl/mem_inst_loader.sv
// Instruction memory with a little-endian byte-stream program loader and a 1-cycle fetch port.
// Define INST_MEM_DEBUG_PORT_EN to add an ungated debug read port (dbg_addr_i / dbg_data_o).
module mem_inst_loader #(
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned NBYTE      = 8,
    parameter int unsigned N_ELEMENTS = 128,
    parameter int unsigned ADDRWIDTH  = $clog2(N_ELEMENTS),
    parameter int unsigned NB_CNT     = ADDRWIDTH + 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 load_en_i,
    input  logic                 byte_valid_i,
    input  logic [NBYTE-1:0]     byte_i,
    input  logic                 en_read_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    output logic [NB_DATA-1:0]   data_o,
    output logic                 busy_o,
    output logic                 load_done_o,
    output logic [NB_CNT-1:0]    load_count_o,
    output logic                 overflow_o
`ifdef INST_MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDRWIDTH-1:0] dbg_addr_i,
    output logic [NB_DATA-1:0]   dbg_data_o
`endif
);

    localparam int unsigned NB_LANES    = NB_DATA / NBYTE;
    localparam int unsigned NB_LANE_CNT = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
    localparam logic [NB_LANE_CNT-1:0] LAST_LANE  = NB_LANE_CNT'(NB_LANES - 1);
    localparam logic [NB_CNT-1:0]      FULL_COUNT = NB_CNT'(N_ELEMENTS);
    localparam logic [ADDRWIDTH-1:0]   LAST_ADDR  = ADDRWIDTH'(N_ELEMENTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

    state_t                 state_q, state_d;
    logic                   load_start, byte_take, word_done, fetch_en;
    logic                   mem_full, mem_we, addr_hit;
    logic [NB_LANE_CNT-1:0] byte_cnt_q;
    logic [NB_DATA-1:0]     word_buf_q, word_next;
    logic [ADDRWIDTH-1:0]   wr_ptr_q;
    logic [NB_CNT-1:0]      load_count_q;
    logic                   overflow_q;
    logic [NB_DATA-1:0]     mem [N_ELEMENTS];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        byte_take  = 1'b0;
        word_done  = 1'b0;
        fetch_en   = 1'b0;
        case (state_q)
            IDLE, READY: begin
                fetch_en = 1'b1;
                if (load_en_i) begin
                    state_d    = LOAD;
                    load_start = 1'b1;
                end
            end
            LOAD: begin
                if (load_en_i) begin
                    byte_take = byte_valid_i;
                    word_done = byte_valid_i && (byte_cnt_q == LAST_LANE);
                end else begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_next = word_buf_q;
        for (int unsigned i = 0; i < NB_LANES; i++) begin
            if (byte_cnt_q == NB_LANE_CNT'(i)) begin
                word_next[i*NBYTE +: NBYTE] = byte_i;
            end
        end
    end

    assign mem_full = (load_count_q == FULL_COUNT);
    assign mem_we   = word_done && !mem_full;

    // wr_ptr saturates at the last word; the full check drops anything beyond it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (load_start) begin
            byte_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (state_q == LOAD) begin
            if (!load_en_i) begin
                byte_cnt_q <= '0;
            end else if (byte_take) begin
                word_buf_q <= word_next;
                if (word_done) begin
                    byte_cnt_q <= '0;
                    if (mem_full) begin
                        overflow_q <= 1'b1;
                    end else begin
                        load_count_q <= load_count_q + NB_CNT'(1);
                        if (wr_ptr_q != LAST_ADDR) begin
                            wr_ptr_q <= wr_ptr_q + ADDRWIDTH'(1);
                        end
                    end
                end else begin
                    byte_cnt_q <= byte_cnt_q + NB_LANE_CNT'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= word_next;
        end
    end

    assign addr_hit = (NB_CNT'(addr_i) < load_count_q);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (flush_i) begin
            data_o <= '0;
        end else if (fetch_en && !stall_i && en_read_i) begin
            data_o <= addr_hit ? mem[addr_i] : '0;
        end
    end

`ifdef INST_MEM_DEBUG_PORT_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            dbg_data_o <= '0;
        end else begin
            dbg_data_o <= mem[dbg_addr_i];
        end
    end
`endif

    assign busy_o       = (state_q == LOAD);
    assign load_done_o  = (state_q == READY);
    assign load_count_o = load_count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mem_inst_loader.sv
// Scoreboard bench for mem_inst_loader: driver queues expectations from a byte-list model,
// a monitor checks them one cycle later.
module tb_mem_inst_loader;

    localparam int unsigned NB_DATA    = 32;
    localparam int unsigned NBYTE      = 8;
    localparam int unsigned N_ELEMENTS = 128;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        load_en_i, byte_valid_i, en_read_i, stall_i, flush_i;
    logic [7:0]  byte_i;
    logic [6:0]  addr_i;
    logic [31:0] data_o;
    logic        busy_o, load_done_o, overflow_o;
    logic [7:0]  load_count_o;
`ifdef INST_MEM_DEBUG_PORT_EN
    logic [6:0]  dbg_addr_i;
    logic [31:0] dbg_data_o;
`endif

    always #5 clock_i = ~clock_i;

    mem_inst_loader #(
        .NB_DATA   (NB_DATA),
        .NBYTE     (NBYTE),
        .N_ELEMENTS(N_ELEMENTS)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load_en_i   (load_en_i),
        .byte_valid_i(byte_valid_i),
        .byte_i      (byte_i),
        .en_read_i   (en_read_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .addr_i      (addr_i),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .load_done_o (load_done_o),
        .load_count_o(load_count_o),
        .overflow_o  (overflow_o)
`ifdef INST_MEM_DEBUG_PORT_EN
        ,
        .dbg_addr_i  (dbg_addr_i),
        .dbg_data_o  (dbg_data_o)
`endif
    );

    typedef struct {
        bit          is_status;
        string       name;
        logic [31:0] data;
        logic [7:0]  cnt;
        bit          ovf, busy, done;
        bit          has_dbg;
        logic [31:0] dbg;
    } exp_t;

    exp_t        exp_q[$];
    bit          chk_v = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: words already visible, count, sticky overflow, fetch output.
    logic [31:0] m_mem [N_ELEMENTS];
    int          m_count = 0;
    bit          m_ovf   = 1'b0;
    logic [31:0] m_dout  = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial begin : monitor
        forever begin
            bit   cv;
            exp_t e;
            @(posedge clock_i);
            cv = chk_v;
            #1;
            if (cv) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, 64'(data_o), 64'(e.data));
                    if (e.is_status) begin
                        check({e.name, "_count"}, 64'(load_count_o), 64'(e.cnt));
                        check({e.name, "_ovf"},   64'(overflow_o),   64'(e.ovf));
                        check({e.name, "_busy"},  64'(busy_o),       64'(e.busy));
                        check({e.name, "_done"},  64'(load_done_o),  64'(e.done));
                    end
`ifdef INST_MEM_DEBUG_PORT_EN
                    if (e.has_dbg) check({e.name, "_dbg"}, 64'(dbg_data_o), 64'(e.dbg));
`endif
                end
            end
        end
    end

    task automatic step();
        @(negedge clock_i);
        chk_v = 1'b0;
    endtask

    task automatic idle_inputs();
        load_en_i = 1'b0; byte_valid_i = 1'b0; byte_i = '0;
        en_read_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; addr_i = '0;
    endtask

    task automatic push_data(input string name, input bit with_dbg, input logic [31:0] dbg_exp);
        exp_t e;
        e.is_status = 1'b0; e.name = name; e.data = m_dout; e.cnt = '0;
        e.ovf = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.has_dbg = with_dbg; e.dbg = dbg_exp;
        exp_q.push_back(e);
        chk_v = 1'b1;
    endtask

    task automatic push_status(input string name, input bit busy, input bit done);
        exp_t e;
        e.is_status = 1'b1; e.name = name; e.data = m_dout; e.cnt = 8'(m_count);
        e.ovf = m_ovf; e.busy = busy; e.done = done; e.has_dbg = 1'b0; e.dbg = '0;
        exp_q.push_back(e);
        chk_v = 1'b1;
    endtask

    task automatic fetch(input logic [6:0] a, input bit en, input bit st, input bit fl, input string name);
        step();
        idle_inputs();
        addr_i = a; en_read_i = en; stall_i = st; flush_i = fl;
        if (fl) m_dout = '0;
        else if (!st && en) m_dout = (int'(a) < m_count) ? m_mem[a] : '0;
        push_data(name, 1'b0, '0);
    endtask

    // Drives a whole load; the model is derived from the byte list as a whole.
    task automatic load(input logic [7:0] bytes[$], input bit finish, input string name);
        int nw;
        step();
        idle_inputs();
        load_en_i = 1'b1;
        byte_valid_i = 1'($urandom_range(0, 1));
        byte_i = 8'($urandom);
        m_count = 0;
        m_ovf = 1'b0;
        push_status({name, "_entry"}, 1'b1, 1'b0);
        foreach (bytes[i]) begin
            while ($urandom_range(0, 3) == 0) begin
                step();
                byte_valid_i = 1'b0;
                byte_i = 8'($urandom);
                en_read_i = 1'($urandom_range(0, 1));
                stall_i = 1'($urandom_range(0, 1));
                addr_i = 7'($urandom);
                flush_i = 1'b0;
                push_data({name, "_gap_hold"}, 1'b0, '0);
            end
            step();
            byte_valid_i = 1'b1;
            byte_i = bytes[i];
            en_read_i = 1'($urandom_range(0, 1));
            stall_i = 1'($urandom_range(0, 1));
            addr_i = 7'($urandom);
            flush_i = ($urandom_range(0, 7) == 0);
            if (flush_i) m_dout = '0;
            push_data({name, "_load_hold"}, 1'b0, '0);
        end
        nw = bytes.size() / 4;
        for (int w = 0; w < nw && w < int'(N_ELEMENTS); w++) begin
            m_mem[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
        end
        m_count = (nw < int'(N_ELEMENTS)) ? nw : int'(N_ELEMENTS);
        m_ovf = (nw > int'(N_ELEMENTS));
        if (finish) begin
            step();
            idle_inputs();
            byte_valid_i = 1'b1;
            byte_i = 8'($urandom);
            en_read_i = 1'b1;
            addr_i = 7'($urandom);
            push_status({name, "_done"}, 1'b0, 1'b1);
        end
    endtask

    initial begin : driver
        logic [7:0] bq[$];
        idle_inputs();
`ifdef INST_MEM_DEBUG_PORT_EN
        dbg_addr_i = '0;
`endif
        reset_i = 1'b1;
        #3;
        check("reset_data",  64'(data_o),       64'd0);
        check("reset_busy",  64'(busy_o),       64'd0);
        check("reset_done",  64'(load_done_o),  64'd0);
        check("reset_count", 64'(load_count_o), 64'd0);
        check("reset_ovf",   64'(overflow_o),   64'd0);
        step();
        reset_i = 1'b0;

        fetch(7'd0, 1'b1, 1'b0, 1'b0, "idle_read_empty");

        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(bq, 1'b1, "basic");
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "read0");
        fetch(7'd1, 1'b1, 1'b0, 1'b0, "read1");
        fetch(7'd2, 1'b1, 1'b0, 1'b0, "read_beyond");
        fetch(7'd1, 1'b1, 1'b0, 1'b0, "read1_again");
        fetch(7'd0, 1'b1, 1'b0, 1'b1, "flush");
        fetch(7'd1, 1'b1, 1'b0, 1'b0, "pre_stall");
        repeat (3) fetch(7'd0, 1'b1, 1'b1, 1'b0, "stall_hold");
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "stall_release");
        fetch(7'd1, 1'b0, 1'b0, 1'b0, "no_enable_hold");

        bq.delete();
        repeat (4 * N_ELEMENTS + 4) bq.push_back(8'($urandom));
        load(bq, 1'b1, "overflow");
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "overflow_word0");
        fetch(7'd127, 1'b1, 1'b0, 1'b0, "overflow_last");

        bq.delete();
        repeat (6) bq.push_back(8'($urandom));
        load(bq, 1'b1, "partial");
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "partial_word0");
        fetch(7'd1, 1'b1, 1'b0, 1'b0, "partial_unreadable");

        bq.delete();
        repeat (4) bq.push_back(8'($urandom));
        load(bq, 1'b1, "reload");
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "reload_word0");

        for (int t = 0; t < 12; t++) begin
            bq.delete();
            repeat ($urandom_range(0, 24)) bq.push_back(8'($urandom));
            load(bq, 1'b1, "rand_load");
            repeat (8) begin
                fetch(7'($urandom_range(0, m_count + 2)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), "rand_fetch");
            end
        end

        fetch(7'd0, 1'b1, 1'b0, 1'b0, "pre_reset_read");
        bq.delete();
        repeat (5) bq.push_back(8'($urandom));
        load(bq, 1'b0, "midload");
        @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        #1;
        m_count = 0; m_ovf = 1'b0; m_dout = '0;
        check("midreset_busy",  64'(busy_o),       64'd0);
        check("midreset_done",  64'(load_done_o),  64'd0);
        check("midreset_count", 64'(load_count_o), 64'd0);
        check("midreset_data",  64'(data_o),       64'd0);
        check("midreset_ovf",   64'(overflow_o),   64'd0);
        step();
        reset_i = 1'b0;
        idle_inputs();
`ifdef INST_MEM_DEBUG_PORT_EN
        dbg_addr_i = '0;
        step();
        push_data("midreset_dbg0", 1'b1, m_mem[0]);
`endif
        fetch(7'd0, 1'b1, 1'b0, 1'b0, "post_reset_gated");

        step();
        idle_inputs();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock_i);
        if (exp_q.size() != 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
